updown_limit_counter: RTL
=========================

# updown_limit_counter

Parametrised up/down counter with a programmable limit, selectable wrap, saturate or one-shot mode, synchronous load and an optional enable prescaler. It is the general-purpose counting primitive for timing, gating and event-count paths in the FPGA design. Terminal-count and busy flags let it drive downstream sequencers directly.

## Interface
- WIDTH, 16, counter and limit width.
- PRESCALE_WIDTH, 8, prescaler ratio width.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; qualifies every tick.
- dir  in  1  1 = count up, 0 = count down.
- mode  in  2  0 WRAP, 1 SAT, 2 ONESHOT, 3 is treated as WRAP.
- limit  in  WIDTH  upper boundary; the lower boundary is fixed at 0.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value loaded into Q.
- start  in  1  one-shot arm/restart strobe; ignored outside ONESHOT.
- prescale  in  PRESCALE_WIDTH  tick every prescale+1 enabled cycles.
- Q  out  WIDTH  count, registered.
- tc  out  1  terminal-count pulse, registered, 1 cycle.
- at_bound  out  1  combinational: (dir && Q>=limit) || (!dir && Q==0).
- busy  out  1  registered; high while the one-shot FSM is in RUN.

## Operation
- tick = en && prescaler expiry. Prescaler counter p: on en, if p>=prescale then p<=0 and tick fires, else p<=p+1. prescale=0 gives a tick on every en cycle.
- Priority per edge: reset > load > start > tick.
- reset: Q=0, p=0, tc=0, busy=0, FSM IDLE.
- load: Q<=load_value, p<=0, tc<=0. FSM state is unchanged.
- Tick away from boundary: Q±1 by dir, WIDTH-bit arithmetic.
- Up boundary is Q>=limit, which covers limit lowered below Q. Down boundary is Q==0.
- WRAP, tick at boundary: up goes to 0, down goes to limit, tc=1 for that cycle.
- SAT, tick at boundary: Q holds and tc stays 0. at_bound remains high.
- ONESHOT FSM has states IDLE, RUN and DONE.
  - start in any state: Q<=0 (dir=1) or limit (dir=0), p<=0, enter RUN.
  - RUN, tick at boundary: Q holds, tc=1, enter DONE.
  - IDLE and DONE ignore ticks.
- Mode change mid-count takes effect on the next tick. Leaving ONESHOT forces the FSM to IDLE.
- tc is 0 on every cycle not listed above.

## Timing
- Q, tc and busy update 1 cycle after the qualifying input edge.
- at_bound is valid in the same cycle as Q (zero latency from Q).
- With prescale=N and en held high, Q advances every N+1 cycles. The first tick comes N+1 cycles after reset, load or start.
- Dropping en freezes both p and Q. There is no partial-tick loss.
- load or start in the same cycle as a tick suppresses that tick.

## Configuration
- Macro UDLC_PRESCALER_EN.
  - Defined: the prescaler is built as described above.
  - Undefined: tick = en, the prescale port is present but ignored, and no p register is synthesised.

## Structure
- Shared package counter_pkg holds:
  - mode encodings MODE_WRAP=2'd0, MODE_SAT=2'd1, MODE_ONESHOT=2'd2;
  - FSM state encodings ST_IDLE, ST_RUN, ST_DONE.
- Sub-module tick_prescaler holds p, the prescale compare and the clear input, and outputs tick. It is instantiated only under UDLC_PRESCALER_EN.

## Test plan
- WRAP up, limit=5, prescale=0, en=1: Q goes 0,1,2,3,4,5,0. tc is high only on the cycle Q returns to 0.
- WRAP down, limit=3, load_value=1 then count: Q goes 1,0,3,2. tc is high on the cycle Q becomes 3.
- SAT up, limit=4: Q holds at 4 for 10 further ticks, tc is never asserted, at_bound=1.
- ONESHOT up, limit=3, prescale=2: start leads to busy=1 and Q steps every 3 cycles 0,1,2,3. Then tc pulses once, busy=0, and Q holds at 3. A second start restarts from 0.
- Collisions:
  - load=1 with load_value=9 in the same cycle as a tick gives Q=9 and no increment;
  - reset asserted mid-RUN gives Q=0, busy=0, tc=0 next cycle.
- Limit lowered: Q=10 while counting up, limit changed to 6 in WRAP. The next tick gives Q=0 and tc=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for updown_limit_counter: count modes and one-shot FSM states.
package counter_pkg;

   localparam logic [1:0] MODE_WRAP    = 2'd0;
   localparam logic [1:0] MODE_SAT     = 2'd1;
   localparam logic [1:0] MODE_ONESHOT = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } os_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: fires tick on every (prescale+1)-th enabled cycle; clear restarts the count.
module tick_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      clear,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tick
);

   logic [PRESCALE_WIDTH-1:0] p;
   logic                      expired;

   // >= rather than == so lowering prescale below p expires on the next enabled cycle
   assign expired = (p >= prescale);
   assign tick    = en && expired;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         p <= '0;
      end else if (en) begin
         if (expired) p <= '0;
         else         p <= p + PRESCALE_WIDTH'(1);
      end
   end

endmodule

// File: rtl/updown_limit_counter.sv
// Up/down counter with programmable limit and wrap/saturate/one-shot modes.
// Define UDLC_PRESCALER_EN to build the enable prescaler; otherwise every enabled cycle ticks.
module updown_limit_counter
   import counter_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      dir,
   input  logic [1:0]                mode,
   input  logic [WIDTH-1:0]          limit,
   input  logic                      load,
   input  logic [WIDTH-1:0]          load_value,
   input  logic                      start,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic [WIDTH-1:0]          Q,
   output logic                      tc,
   output logic                      at_bound,
   output logic                      busy
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   os_state_t  state, state_next;
   logic       is_oneshot;
   logic       arm;
   logic       tick;
   logic [WIDTH-1:0] stepped;

   assign is_oneshot = (mode == MODE_ONESHOT);
   assign arm        = start && is_oneshot;
   assign at_bound   = dir ? (Q >= limit) : (Q == '0);
   assign stepped    = dir ? (Q + ONE) : (Q - ONE);

`ifdef UDLC_PRESCALER_EN
   tick_prescaler #(
      .PRESCALE_WIDTH(PRESCALE_WIDTH)
   ) u_prescaler (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .clear    (load || arm),
      .prescale (prescale),
      .tick     (tick)
   );
`else
   logic unused_prescale;
   assign unused_prescale = ^prescale;
   assign tick            = en;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Leaving ONESHOT overrides everything, including a load, so no stale RUN survives a mode change.
   always_comb begin
      state_next = state;
      if (!is_oneshot) begin
         state_next = ST_IDLE;
      end else if (load) begin
         state_next = state;
      end else if (start) begin
         state_next = ST_RUN;
      end else if (tick && (state == ST_RUN) && at_bound) begin
         state_next = ST_DONE;
      end
   end

   always_comb begin
      busy = (state == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         Q  <= '0;
         tc <= 1'b0;
      end else if (load) begin
         Q  <= load_value;
         tc <= 1'b0;
      end else if (arm) begin
         Q  <= dir ? '0 : limit;
         tc <= 1'b0;
      end else if (tick) begin
         tc <= 1'b0;
         case (mode)
            MODE_SAT: begin
               if (!at_bound) Q <= stepped;
            end
            MODE_ONESHOT: begin
               if (state == ST_RUN) begin
                  if (at_bound) tc <= 1'b1;
                  else          Q  <= stepped;
               end
            end
            default: begin
               if (at_bound) begin
                  Q  <= dir ? '0 : limit;
                  tc <= 1'b1;
               end else begin
                  Q  <= stepped;
               end
            end
         endcase
      end else begin
         tc <= 1'b0;
      end
   end

endmodule
